// File: rtl/affine_pkg.sv
// Shared types and constants for the rotozoom affine u/v stepper.
package affine_pkg;

   localparam int DEF_TRIG_W     = 16;
   localparam int DEF_COORD_W    = 17;
   localparam int DEF_ZOOM_SHIFT = 5;

   localparam int SHIFT_TOTAL = DEF_TRIG_W + DEF_ZOOM_SHIFT;
   localparam int A           = DEF_COORD_W + 2;

   typedef logic signed [A-1:0]          coord_t;
   typedef logic signed [DEF_TRIG_W-1:0] trig_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_US,
      S_MUL_VS,
      S_MUL_UO,
      S_MUL_VO,
      S_COMMIT
   } state_t;

endpackage

// File: rtl/mult_seq.sv
// Signed radix-2 shift-add multiplier, W x W -> 2W.
// Load takes one cycle, then W add steps; done pulses with the product.
module mult_seq #(
   parameter int W = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  start,
   input  logic signed [W-1:0]   a,
   input  logic signed [W-1:0]   b,
   output logic                  done,
   output logic signed [2*W-1:0] p
);

   localparam int CW = $clog2(W);

   logic                  run;
   logic [CW-1:0]         cnt;
   logic signed [2*W-1:0] acc;
   logic signed [2*W-1:0] mc;
   logic [W-1:0]          mp;
   logic                  last;
   logic signed [2*W-1:0] addend;
   logic signed [2*W-1:0] acc_nx;

   assign last = (cnt == CW'(W - 1));

   // The multiplier MSB carries negative weight in two's complement.
   always_comb begin
      addend = '0;
      if (mp[0])
         addend = last ? -mc : mc;
      acc_nx = acc + addend;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         run  <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
         acc  <= '0;
         mc   <= '0;
         mp   <= '0;
         p    <= '0;
      end else begin
         done <= 1'b0;
         if (start && !run) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= '0;
            mc  <= (2*W)'(a);
            mp  <= b;
         end else if (run) begin
            acc <= acc_nx;
            mc  <= mc <<< 1;
            mp  <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
               run  <= 1'b0;
               done <= 1'b1;
               p    <= acc_nx;
            end
         end
      end
   end

endmodule

// File: rtl/affine_uv_stepper.sv
// Per-frame affine u/v generator: computes strides on frame_start with a
// shared sequential multiplier, then steps u/v per pixel and per line.
module affine_uv_stepper
   import affine_pkg::*;
#(
   parameter int TRIG_W     = DEF_TRIG_W,
   parameter int COORD_W    = DEF_COORD_W,
   parameter int ZOOM_SHIFT = DEF_ZOOM_SHIFT,
   parameter int CENTRE_X   = 320,
   parameter int CENTRE_Y   = 240,
   parameter int TEX_BITS   = 7,
   parameter int WRAP_MODE  = 1
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       frame_start,
   input  logic signed [TRIG_W-1:0]   sin_in,
   input  logic signed [TRIG_W-1:0]   cos_in,
   input  logic signed [TRIG_W-1:0]   scale_in,
   input  logic                       line_start,
   input  logic                       pix_en,
   output logic                       busy,
   output logic                       params_ready,
   output logic                       overrun,
   output logic [TEX_BITS-1:0]        tex_x,
   output logic [TEX_BITS-1:0]        tex_y,
   output logic                       border,
   output logic                       uv_valid
);

   localparam int AW = COORD_W + 2;
   localparam int SH = TRIG_W + ZOOM_SHIFT;

   state_t state;

   logic signed [TRIG_W-1:0]   sin_q, cos_q, scale_q;
   logic signed [TRIG_W-1:0]   op_a, op_b;
   logic                       mul_start, mul_done;
   logic signed [2*TRIG_W-1:0] prod;
   logic signed [AW-1:0]       res;

   logic signed [AW-1:0] us_q, vs_q, uo_q, vo_q;
   logic signed [AW-1:0] u_stride, v_stride;
   logic signed [AW-1:0] u_start, v_start;
   logic signed [AW-1:0] u, v;

   assign busy         = (state != S_IDLE) && (state != S_COMMIT);
   assign params_ready = (state == S_COMMIT);
   assign res          = AW'(prod >>> SH);

   always_comb begin
      op_a = '0;
      op_b = '0;
      unique case (state)
         S_MUL_US: begin op_a = scale_q;            op_b = cos_q; end
         S_MUL_VS: begin op_a = scale_q;            op_b = sin_q; end
         S_MUL_UO: begin op_a = TRIG_W'(CENTRE_X); op_b = cos_q; end
         S_MUL_VO: begin op_a = TRIG_W'(CENTRE_Y); op_b = sin_q; end
         default: ;
      endcase
   end

   mult_seq #(.W(TRIG_W)) u_mult (
      .CLK   (CLK),
      .RESET (RESET),
      .start (mul_start),
      .a     (op_a),
      .b     (op_b),
      .done  (mul_done),
      .p     (prod)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         mul_start <= 1'b0;
         overrun   <= 1'b0;
         sin_q     <= '0;
         cos_q     <= '0;
         scale_q   <= '0;
         us_q      <= '0;
         vs_q      <= '0;
         uo_q      <= '0;
         vo_q      <= '0;
      end else begin
         mul_start <= 1'b0;
         overrun   <= frame_start && busy;
         unique case (state)
            S_IDLE: if (frame_start) begin
               sin_q     <= sin_in;
               cos_q     <= cos_in;
               scale_q   <= scale_in;
               mul_start <= 1'b1;
               state     <= S_MUL_US;
            end
            S_MUL_US: if (mul_done) begin
               us_q      <= res;
               mul_start <= 1'b1;
               state     <= S_MUL_VS;
            end
            S_MUL_VS: if (mul_done) begin
               vs_q      <= res;
               mul_start <= 1'b1;
               state     <= S_MUL_UO;
            end
            S_MUL_UO: if (mul_done) begin
               uo_q      <= res;
               mul_start <= 1'b1;
               state     <= S_MUL_VO;
            end
            S_MUL_VO: if (mul_done) begin
               vo_q  <= res;
               state <= S_COMMIT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Commit overrides the line_start start-advance in the same cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         u_stride <= '0;
         v_stride <= '0;
         u_start  <= '0;
         v_start  <= '0;
         u        <= '0;
         v        <= '0;
         uv_valid <= 1'b0;
      end else begin
         uv_valid <= line_start | pix_en;
         if (line_start) begin
            u       <= u_start;
            v       <= v_start;
            u_start <= u_start + v_stride;
            v_start <= v_start - u_stride;
         end else if (pix_en) begin
            u <= u + u_stride;
            v <= v + v_stride;
         end
         if (state == S_COMMIT) begin
            u_stride <= us_q;
            v_stride <= vs_q;
            u_start  <= -uo_q;
            v_start  <= vo_q;
         end
      end
   end

   assign tex_x  = u[COORD_W-1 -: TEX_BITS];
   assign tex_y  = v[COORD_W-1 -: TEX_BITS];
   assign border = (WRAP_MODE == 0) &&
                   ((u[AW-1 -: 2] != 2'b00) || (v[AW-1 -: 2] != 2'b00));

endmodule

// File: tb/tb_affine_uv_stepper.sv
// Bench for affine_uv_stepper: directed table, hand sequences, random run.
module tb_affine_uv_stepper;
   import affine_pkg::*;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic  RESET, frame_start, line_start, pix_en;
   trig_t sin_in, cos_in, scale_in;

   logic       busy0, pr0, ov0, bd0, val0;
   logic [6:0] tx0, ty0;
   logic       busy1, pr1, ov1, bd1, val1;
   logic [6:0] tx1, ty1;

   affine_uv_stepper #(.WRAP_MODE(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .frame_start(frame_start),
      .sin_in(sin_in), .cos_in(cos_in), .scale_in(scale_in),
      .line_start(line_start), .pix_en(pix_en),
      .busy(busy0), .params_ready(pr0), .overrun(ov0),
      .tex_x(tx0), .tex_y(ty0), .border(bd0), .uv_valid(val0)
   );

   affine_uv_stepper #(.WRAP_MODE(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .frame_start(frame_start),
      .sin_in(sin_in), .cos_in(cos_in), .scale_in(scale_in),
      .line_start(line_start), .pix_en(pix_en),
      .busy(busy1), .params_ready(pr1), .overrun(ov1),
      .tex_x(tx1), .tex_y(ty1), .border(bd1), .uv_valid(val1)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: coordinates kept modulo 2^19.
   logic [18:0] mu, mv, mus, mvs, mu0, mv0;
   logic [18:0] pus, pvs, pu0, pv0;
   bit          inf;
   int          cnt;
   bit          e_ov, e_val;

   function automatic logic [18:0] scaled(input longint x, input longint y);
      longint p;
      p = (x * y) >>> 21;
      return p[18:0];
   endfunction

   task automatic step(input bit rs, input bit fs, input bit ls,
                       input bit pe, input trig_t s, input trig_t c,
                       input trig_t z);
      bit          cm;
      logic [18:0] nu0, nv0;
      bit          e_bd;
      RESET = rs; frame_start = fs; line_start = ls; pix_en = pe;
      sin_in = s; cos_in = c; scale_in = z;
      @(posedge CLK);
      if (rs) begin
         mu = '0; mv = '0; mus = '0; mvs = '0; mu0 = '0; mv0 = '0;
         inf = 0; cnt = 0; e_ov = 0; e_val = 0;
      end else begin
         cm    = inf && (cnt == 73);
         e_ov  = fs && inf && (cnt >= 1) && (cnt <= 72);
         e_val = ls | pe;
         nu0 = mu0;
         nv0 = mv0;
         if (ls) begin
            mu = mu0; mv = mv0;
            nu0 = mu0 + mvs;
            nv0 = mv0 - mus;
         end else if (pe) begin
            mu = mu + mus;
            mv = mv + mvs;
         end
         mu0 = nu0;
         mv0 = nv0;
         if (cm) begin
            mus = pus; mvs = pvs; mu0 = pu0; mv0 = pv0;
            inf = 0;
         end else if (fs && !inf) begin
            pus = scaled(z, c);
            pvs = scaled(z, s);
            pu0 = 19'(0) - scaled(320, c);
            pv0 = scaled(240, s);
            inf = 1;
            cnt = 0;
         end
         if (inf) cnt++;
      end
      #1;
      e_bd = (mu[18:17] != 2'b00) || (mv[18:17] != 2'b00);
      chk("busy",     busy0, inf && cnt >= 1 && cnt <= 72);
      chk("ready",    pr0,   inf && cnt == 73);
      chk("overrun",  ov0,   e_ov);
      chk("uv_valid", val0,  e_val);
      chk("tex_x",    tx0,   mu[16:10]);
      chk("tex_y",    ty0,   mv[16:10]);
      chk("border",   bd0,   e_bd);
      chk("tex_x_wrap", tx1, mu[16:10]);
      chk("border_wrap", bd1, 1'b0);
      @(negedge CLK);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0, '0, '0);
   endtask

   typedef struct {
      trig_t c;
      trig_t s;
      trig_t z;
      int    npix;
      int    tx;
      int    ty;
      int    bd;
   } vec_t;

   vec_t vt[4];

   initial begin
      int k, n_pr, n_ov, at;
      vt[0] = '{c: 32767,  s: 0,     z: 32767, npix: 0,   tx: 127, ty: 0, bd: 1};
      vt[1] = '{c: 32767,  s: 0,     z: 32767, npix: 100, tx: 49,  ty: 0, bd: 0};
      vt[2] = '{c: 0,      s: 32767, z: 32767, npix: 10,  tx: 0,   ty: 4, bd: 0};
      vt[3] = '{c: -32768, s: 0,     z: 16384, npix: 1,   tx: 127, ty: 0, bd: 1};

      RESET = 1; frame_start = 0; line_start = 0; pix_en = 0;
      sin_in = '0; cos_in = '0; scale_in = '0;
      @(negedge CLK);

      repeat (3) step(1, 0, 1, 1, '0, '0, '0);
      step(0, 0, 1, 0, '0, '0, '0);

      foreach (vt[i]) begin
         step(0, 1, 0, 0, vt[i].s, vt[i].c, vt[i].z);
         k = 1;
         while (!pr0 && k < 200) begin
            idle();
            k++;
         end
         chk("row_latency", k, 73);
         idle();
         step(0, 0, 1, 0, '0, '0, '0);
         for (int j = 0; j < vt[i].npix; j++)
            step(0, 0, 0, 1, '0, '0, '0);
         chk("row_tex_x",  tx0, vt[i].tx);
         chk("row_tex_y",  ty0, vt[i].ty);
         chk("row_border", bd0, vt[i].bd);
      end

      // line_start and pix_en together: load only, no stride added.
      step(0, 0, 1, 1, '0, '0, '0);
      chk("ls_pe_tex_x", tx0, 0);

      // Second frame_start while busy.
      step(0, 1, 0, 0, 16'sd1000, 16'sd2000, 16'sd3000);
      n_pr = 0; n_ov = 0; at = 0;
      for (int i = 1; i <= 90; i++) begin
         step(0, i == 10, 0, 0, 16'sd111, 16'sd222, 16'sd333);
         if (pr0) begin n_pr++; at = i + 1; end
         if (ov0) n_ov++;
      end
      chk("ovr_ready_count", n_pr, 1);
      chk("ovr_ready_cycle", at, 73);
      chk("ovr_pulses", n_ov, 1);

      // Reset in the middle of the second product.
      step(0, 1, 0, 0, 16'sd500, -16'sd700, 16'sd20000);
      repeat (25) idle();
      step(1, 0, 1, 1, '0, '0, '0);
      chk("rst_busy", busy0, 0);
      n_pr = 0;
      repeat (80) begin
         idle();
         if (pr0) n_pr++;
      end
      chk("rst_no_ready", n_pr, 0);
      step(0, 1, 0, 0, 16'sd500, -16'sd700, 16'sd20000);
      k = 1;
      while (!pr0 && k < 200) begin
         idle();
         k++;
      end
      chk("rst_relatency", k, 73);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 599) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
              trig_t'($urandom), trig_t'($urandom), trig_t'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/affine_uv_stepper.md
Name: affine_uv_stepper

Overview:
- Parametrised, per-frame-reprogrammable affine texture-coordinate generator for the rotozoom path.
- Sits between VGASyncGen and the texture ROM.
- On each frame boundary it takes sin/cos/scale samples and computes the u/v strides and centre offsets with one shared sequential multiplier, then commits them atomically.
- During active video it steps u/v per pixel and per line, emitting texture indices plus an out-of-texture border flag.

Parameters:
- TRIG_W, 16: signed width of sin/cos/scale inputs; product shift base.
- COORD_W, 17: width of the u/v fixed-point coordinate (index bits at the top).
- ZOOM_SHIFT, 5: extra right shift applied to every product (texel magnification).
- CENTRE_X, 320: rotation centre, x.
- CENTRE_Y, 240: rotation centre, y.
- TEX_BITS, 7: texture index width per axis.
- WRAP_MODE, 1: 1 = tile the texture (border never set); 0 = flag out-of-range coordinates.

Ports:
- CLK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at vsync falling edge
- sin_in  in  TRIG_W  signed sine sample, sampled on frame_start
- cos_in  in  TRIG_W  signed cosine sample, sampled on frame_start
- scale_in  in  TRIG_W  signed zoom sample, sampled on frame_start
- line_start  in  1  first active pixel of a line (xpos==0 && active)
- pix_en  in  1  active pixel, not first
- busy  out  1  parameter computation in progress
- params_ready  out  1  one-cycle pulse when new parameters are committed
- overrun  out  1  one-cycle pulse when frame_start arrives while busy
- tex_x  out  TEX_BITS  texture column index
- tex_y  out  TEX_BITS  texture row index
- border  out  1  coordinate outside texture (WRAP_MODE=0 only)
- uv_valid  out  1  tex_x/tex_y/border valid this cycle

Behaviour:
- Reset: every output is 0; all stride, offset, start and accumulator registers are 0; FSM is IDLE. RESET takes effect mid-computation and mid-line with no residue.
- FSM states: IDLE, MUL_US, MUL_VS, MUL_UO, MUL_VO, COMMIT.
  - IDLE --frame_start--> MUL_US. sin/cos/scale are latched and busy=1.
  - Each MUL_* state starts mult_seq. It advances when done, storing:
    - us = (scale*cos)>>>(TRIG_W+ZOOM_SHIFT)
    - vs = (scale*sin)>>>(TRIG_W+ZOOM_SHIFT)
    - uo = (CENTRE_X*cos)>>>(TRIG_W+ZOOM_SHIFT)
    - vo = (CENTRE_Y*sin)>>>(TRIG_W+ZOOM_SHIFT)
  - All shifts are arithmetic. Results are truncated to the accumulator width A = COORD_W+2.
  - COMMIT (1 cycle): live strides <= us, vs; u_start <= -uo; v_start <= vo; params_ready=1; busy=0; next state IDLE.
- Latency: frame_start to params_ready = 4*(TRIG_W+2)+1 cycles, which is 73 for defaults. This must be a fixed value.
- frame_start while busy: ignored, overrun pulses, and the computation in flight continues unchanged.
- Stepping runs every cycle regardless of busy. Old parameters stay in use until COMMIT.
- line_start: u <= u_start, v <= v_start, u_start <= u_start + v_stride, v_start <= v_start - u_stride.
- pix_en: u <= u + u_stride, v <= v + v_stride.
- line_start and pix_en together: line_start wins. COMMIT and line_start in the same cycle: COMMIT writes the starts and line_start loads the pre-commit u_start into u.
- All arithmetic is signed A-bit two's complement and wraps silently.
- Outputs are registered one cycle after line_start/pix_en:
  - tex_x = u[COORD_W-1 -: TEX_BITS]
  - tex_y = v[COORD_W-1 -: TEX_BITS]
  - Both are taken from the post-update value.
  - uv_valid = 1 that cycle.
- border: WRAP_MODE=1 gives border=0 always. WRAP_MODE=0 gives border=1 when u[A-1:A-2] != 2'b00 or v[A-1:A-2] != 2'b00.

Decomposition:
- Package affine_pkg holds:
  - typedef for the A-bit signed coordinate;
  - typedef for the TRIG_W signed sample;
  - FSM state enum;
  - localparams SHIFT_TOTAL = TRIG_W+ZOOM_SHIFT and A.
- Sub-module mult_seq:
  - signed radix-2 shift-add multiplier, TRIG_W x TRIG_W producing 2*TRIG_W;
  - start/done handshake, TRIG_W+2 cycles per product.
  - start while running is ignored.

Test Plan:
- RESET for 3 cycles with line_start and pix_en held high -> all outputs 0; after release busy=0 and tex_x=tex_y=0 on the next pixel.
- cos=32767, sin=0, scale=32767, frame_start -> params_ready 73 cycles later with u_stride=511, v_stride=0, u_start=-4; next line_start gives tex_x=127 (wrap), border=1 when WRAP_MODE=0.
- After the previous case, line_start then 100 pix_en -> u = -4+100*511 = 51096, tex_x = 51096>>10 = 49 (bits [16:10]); v constant so tex_y=0.
- Second frame_start 10 cycles after the first -> overrun pulse, then exactly one params_ready at cycle 73.
- line_start and pix_en asserted together -> u loads u_start (no stride added); u_start advances by v_stride.
- RESET asserted in MUL_VS -> FSM IDLE, busy=0, no params_ready; a following frame_start completes normally in 73 cycles.
